// File: rtl/sigma_stim_sequencer.sv
// sigma_stim_sequencer
//   Programmable stimulus sequencer feeding one flexdpe input port. A host or
//   DMA engine loads a DEPTH-entry command table. A start pulse then replays
//   entries 0..nent-1 for nrep passes. On every pass after the first,
//   stationary entries are suppressed, so the stationary operands already held
//   in the PEs are reused while the streaming entries repeat. The i_ready input
//   applies back-pressure.
//
// Ports
//   clk, rst                      clock; synchronous active-low reset
//   i_wr_en/addr/data/dest/vn/
//   i_wr_stationary/i_wr_valid    table write port (ignored while running)
//   i_start, i_num_entries,
//   i_repeat                      start pulse and sequence parameters
//   i_abort                       abandon the current sequence
//   i_ready                       downstream accepts this cycle
//   o_data_valid, o_data_bus,
//   o_stationary, o_dest_bus,
//   o_vn_seperator                registered flexdpe input port
//   o_busy, o_done,
//   o_issue_count                 status outputs
//
// state | meaning
// IDLE  | table writable, data outputs 0, waiting for i_start
// RUN   | replaying the table, table locked
// DONE  | one cycle before returning to IDLE; o_done pulses from here
module sigma_stim_sequencer #(
  parameter int IN_DATA_TYPE = 16,
  parameter int NUM_PES      = 32,
  parameter int LOG2_PES     = 5,
  parameter int DEPTH        = 16,
  parameter int LOG2_DEPTH   = 4,
  parameter int REP_W        = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_wr_en,
  input  logic [LOG2_DEPTH-1:0]            i_wr_addr,
  input  logic [NUM_PES*IN_DATA_TYPE-1:0]  i_wr_data,
  input  logic [NUM_PES*LOG2_PES-1:0]      i_wr_dest,
  input  logic [NUM_PES*LOG2_PES-1:0]      i_wr_vn,
  input  logic                             i_wr_stationary,
  input  logic                             i_wr_valid,
  input  logic                             i_start,
  input  logic [LOG2_DEPTH:0]              i_num_entries,
  input  logic [REP_W-1:0]                 i_repeat,
  input  logic                             i_abort,
  input  logic                             i_ready,
  output logic                             o_data_valid,
  output logic [NUM_PES*IN_DATA_TYPE-1:0]  o_data_bus,
  output logic                             o_stationary,
  output logic [NUM_PES*LOG2_PES-1:0]      o_dest_bus,
  output logic [NUM_PES*LOG2_PES-1:0]      o_vn_seperator,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [15:0]                      o_issue_count
);

  localparam int DW = NUM_PES * IN_DATA_TYPE;
  localparam int AW = NUM_PES * LOG2_PES;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [LOG2_DEPTH:0]   DEPTH_C  = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   NENT_ONE = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);
  localparam logic [REP_W:0]        PASS_ONE = (REP_W+1)'(1);
  localparam logic [REP_W-1:0]      REP_ONE  = REP_W'(1);

  // Command table (not reset)
  logic [DW-1:0] data_mem  [DEPTH];
  logic [AW-1:0] dest_mem  [DEPTH];
  logic [AW-1:0] vn_mem    [DEPTH];
  logic          stat_mem  [DEPTH];
  logic          valid_mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;
  logic [REP_W-1:0]      pass_q, pass_d;
  logic [LOG2_DEPTH:0]   nent_q, nent_d;
  logic [REP_W-1:0]      nrep_q, nrep_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  stat_q, stat_d;
  logic [DW-1:0]         data_q, data_d;
  logic [AW-1:0]         dest_q, dest_d;
  logic [AW-1:0]         vn_q, vn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [LOG2_DEPTH:0]   nent_req;
  logic [REP_W-1:0]      nrep_req;
  logic [LOG2_DEPTH:0]   nent_last;
  logic [REP_W:0]        pass_inc;
  logic                  last_entry;
  logic                  last_pass;
  logic                  suppress;

  always_ff @(posedge clk) begin
    if (i_wr_en && (state_q != ST_RUN)) begin
      data_mem[i_wr_addr]  <= i_wr_data;
      dest_mem[i_wr_addr]  <= i_wr_dest;
      vn_mem[i_wr_addr]    <= i_wr_vn;
      stat_mem[i_wr_addr]  <= i_wr_stationary;
      valid_mem[i_wr_addr] <= i_wr_valid;
    end
  end

  assign nent_req   = (i_num_entries > DEPTH_C) ? DEPTH_C : i_num_entries;
  assign nrep_req   = (i_repeat == '0) ? REP_ONE : i_repeat;
  assign nent_last  = nent_q - NENT_ONE;
  assign pass_inc   = {1'b0, pass_q} + PASS_ONE;
  assign last_entry = ({1'b0, ptr_q} == nent_last);
  assign last_pass  = (pass_inc == {1'b0, nrep_q});
  // Stationary operands are already resident in the PEs after the first pass.
  assign suppress   = stat_mem[ptr_q] && (pass_q != '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pass_d  = pass_q;
    nent_d  = nent_q;
    nrep_d  = nrep_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    stat_d  = 1'b0;
    data_d  = '0;
    dest_d  = '0;
    vn_d    = '0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          nent_d = nent_req;
          nrep_d = nrep_req;
          cnt_d  = '0;
          ptr_d  = '0;
          pass_d = '0;
          if (nent_req == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (i_ready) begin
          if (!suppress) begin
            valid_d = valid_mem[ptr_q];
            stat_d  = stat_mem[ptr_q];
            data_d  = data_mem[ptr_q];
            dest_d  = dest_mem[ptr_q];
            vn_d    = vn_mem[ptr_q];
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
          if (last_entry) begin
            ptr_d  = '0;
            pass_d = pass_inc[REP_W-1:0];
            if (last_pass) state_d = ST_DONE;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // An empty start already pulsed o_done on entry; otherwise pulse now.
        if (!i_abort) done_d = !done_q;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      pass_q  <= '0;
      nent_q  <= '0;
      nrep_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      stat_q  <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      vn_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pass_q  <= pass_d;
      nent_q  <= nent_d;
      nrep_q  <= nrep_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      stat_q  <= stat_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      vn_q    <= vn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_data_valid   = valid_q;
  assign o_data_bus     = data_q;
  assign o_stationary   = stat_q;
  assign o_dest_bus     = dest_q;
  assign o_vn_seperator = vn_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_issue_count  = cnt_q;

endmodule

// File: tb/tb_sigma_stim_sequencer.sv
// tb_sigma_stim_sequencer
//   Scoreboard bench for sigma_stim_sequencer. Each run builds the expected
//   per-cycle output stream from a behavioural model of the table replay,
//   queues it, then drives the run and pops/compares one entry per cycle.
module tb_sigma_stim_sequencer;

  localparam int DW = 512;
  localparam int AW = 160;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_wr_en;
  logic [3:0]      i_wr_addr;
  logic [DW-1:0]   i_wr_data;
  logic [AW-1:0]   i_wr_dest;
  logic [AW-1:0]   i_wr_vn;
  logic            i_wr_stationary;
  logic            i_wr_valid;
  logic            i_start;
  logic [4:0]      i_num_entries;
  logic [7:0]      i_repeat;
  logic            i_abort;
  logic            i_ready;
  logic            o_data_valid;
  logic [DW-1:0]   o_data_bus;
  logic            o_stationary;
  logic [AW-1:0]   o_dest_bus;
  logic [AW-1:0]   o_vn_seperator;
  logic            o_busy;
  logic            o_done;
  logic [15:0]     o_issue_count;

  sigma_stim_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .i_wr_en         (i_wr_en),
    .i_wr_addr       (i_wr_addr),
    .i_wr_data       (i_wr_data),
    .i_wr_dest       (i_wr_dest),
    .i_wr_vn         (i_wr_vn),
    .i_wr_stationary (i_wr_stationary),
    .i_wr_valid      (i_wr_valid),
    .i_start         (i_start),
    .i_num_entries   (i_num_entries),
    .i_repeat        (i_repeat),
    .i_abort         (i_abort),
    .i_ready         (i_ready),
    .o_data_valid    (o_data_valid),
    .o_data_bus      (o_data_bus),
    .o_stationary    (o_stationary),
    .o_dest_bus      (o_dest_bus),
    .o_vn_seperator  (o_vn_seperator),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_issue_count   (o_issue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          s;
    logic [DW-1:0] d;
    logic [AW-1:0] dest;
    logic [AW-1:0] vn;
    logic          busy;
    logic          done;
    logic [15:0]   cnt;
  } exp_t;

  typedef struct packed {
    logic ready;
    logic abort;
    logic rst;
    logic wr;
  } ctl_t;

  exp_t exp_q[$];
  ctl_t ctl_q[$];

  logic [DW-1:0] t_data  [16];
  logic [AW-1:0] t_dest  [16];
  logic [AW-1:0] t_vn    [16];
  logic          t_stat  [16];
  logic          t_valid [16];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_out(input exp_t e);
    check("valid", 512'(o_data_valid), 512'(e.v));
    check("stationary", 512'(o_stationary), 512'(e.s));
    check("data", o_data_bus, e.d);
    check("dest", 512'(o_dest_bus), 512'(e.dest));
    check("vn", 512'(o_vn_seperator), 512'(e.vn));
    check("busy", 512'(o_busy), 512'(e.busy));
    check("done", 512'(o_done), 512'(e.done));
    check("issue_count", 512'(o_issue_count), 512'(e.cnt));
  endtask

  // Expected stream model: one exp entry per edge from the start edge on,
  // one ctl entry per edge after the start edge.
  task automatic build(input int n_req, input int rep_req, input int mode,
                       input int abort_k, input int rst_k, input int wr_k);
    int n, r, ptr, pass, k;
    logic [15:0] cnt;
    exp_t e;
    ctl_t c;
    bit fin;
    n = (n_req > 16) ? 16 : n_req;
    r = (rep_req == 0) ? 1 : rep_req;
    cnt = '0; ptr = 0; pass = 0;
    e = '0; e.busy = (n != 0); e.done = (n == 0);
    exp_q.push_back(e);
    if (n == 0) begin
      c = '0; c.ready = 1'b1; ctl_q.push_back(c);
      e = '0; exp_q.push_back(e);
      return;
    end
    fin = 0; k = 1;
    while (!fin) begin
      c = '0;
      c.ready = (mode == 0) ? 1'b1 : k[0];
      c.abort = (k == abort_k);
      c.rst   = (k == rst_k);
      c.wr    = (k == wr_k);
      ctl_q.push_back(c);
      e = '0;
      if (c.rst) begin
        cnt = '0; e.cnt = cnt; exp_q.push_back(e); fin = 1;
      end else if (c.abort) begin
        e.cnt = cnt; exp_q.push_back(e); fin = 1;
      end else begin
        if (c.ready) begin
          if (!(t_stat[ptr] && pass > 0)) begin
            if (cnt != 16'hFFFF) cnt++;
            e.v = t_valid[ptr]; e.s = t_stat[ptr];
            e.d = t_data[ptr]; e.dest = t_dest[ptr]; e.vn = t_vn[ptr];
          end
          if (ptr == n - 1) begin
            ptr = 0; pass++;
            if (pass == r) fin = 1;
          end else begin
            ptr++;
          end
        end
        e.cnt = cnt; e.busy = !fin;
        exp_q.push_back(e);
        if (fin) begin
          c = '0; ctl_q.push_back(c);
          e = '0; e.done = 1'b1; e.cnt = cnt; exp_q.push_back(e);
        end
      end
      k++;
    end
    c = '0; ctl_q.push_back(c);
    e = '0; e.cnt = cnt; exp_q.push_back(e);
  endtask

  task automatic run(input int n_req, input int rep_req, input bit wr_at_start);
    ctl_t c;
    i_start = 1'b1; i_num_entries = 5'(n_req); i_repeat = 8'(rep_req);
    if (wr_at_start) begin
      i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_data = t_data[0]; i_wr_dest = t_dest[0];
      i_wr_vn = t_vn[0]; i_wr_stationary = t_stat[0]; i_wr_valid = t_valid[0];
    end
    @(negedge clk);
    i_start = 1'b0; i_wr_en = 1'b0;
    cmp_out(exp_q.pop_front());
    while (ctl_q.size() > 0) begin
      c = ctl_q.pop_front();
      i_ready = c.ready; i_abort = c.abort; rst = !c.rst;
      if (c.wr) begin
        i_wr_en = 1'b1; i_wr_addr = 4'd1; i_wr_data = ~t_data[1]; i_wr_dest = ~t_dest[1];
        i_wr_vn = ~t_vn[1]; i_wr_stationary = 1'b1; i_wr_valid = 1'b0;
      end
      @(negedge clk);
      i_wr_en = 1'b0; i_abort = 1'b0; rst = 1'b1;
      if (exp_q.size() > 0) cmp_out(exp_q.pop_front());
    end
    check("sb_empty", 512'(exp_q.size()), 512'(0));
    exp_q.delete();
    i_ready = 1'b1;
  endtask

  task automatic load(input int a);
    i_wr_en = 1'b1; i_wr_addr = 4'(a); i_wr_data = t_data[a]; i_wr_dest = t_dest[a];
    i_wr_vn = t_vn[a]; i_wr_stationary = t_stat[a]; i_wr_valid = t_valid[a];
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  initial begin
    exp_t z;
    rst = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_wr_dest = '0;
    i_wr_vn = '0; i_wr_stationary = 1'b0; i_wr_valid = 1'b0; i_start = 1'b0;
    i_num_entries = '0; i_repeat = '0; i_abort = 1'b0; i_ready = 1'b1;

    for (int i = 0; i < 16; i++) begin
      for (int w = 0; w < 16; w++) t_data[i][w*32 +: 32] = $urandom;
      for (int w = 0; w < 5; w++) begin
        t_dest[i][w*32 +: 32] = $urandom;
        t_vn[i][w*32 +: 32]   = $urandom;
      end
      t_stat[i]  = (i == 0);
      t_valid[i] = (i != 12);
    end
    for (int l = 0; l < 32; l++) t_data[0][l*16 +: 16] = 16'h3F80;

    repeat (3) @(negedge clk);
    z = '0;
    cmp_out(z);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) load(i);

    build(6, 1, 0, 0, 0, 0);  run(6, 1, 0);
    build(6, 3, 0, 0, 0, 0);  run(6, 3, 0);
    build(6, 1, 1, 0, 0, 0);  run(6, 1, 0);
    build(0, 1, 0, 0, 0, 0);  run(0, 1, 0);
    build(20, 1, 0, 0, 0, 0); run(20, 1, 0);
    build(6, 0, 0, 0, 0, 0);  run(6, 0, 0);
    // abort after the third issue, with a write attempted mid-run
    build(6, 1, 0, 4, 0, 2);  run(6, 1, 0);
    build(6, 1, 0, 0, 0, 0);  run(6, 1, 0);
    // reset mid-run, then replay the intact table
    build(6, 2, 0, 0, 3, 0);  run(6, 2, 0);
    build(6, 2, 0, 0, 0, 0);  run(6, 2, 0);
    // write coinciding with start: new entry 0 is used from the first issue
    for (int w = 0; w < 16; w++) t_data[0][w*32 +: 32] = $urandom;
    t_stat[0] = 1'b0;
    build(2, 2, 0, 0, 0, 0);  run(2, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sigma_stim_sequencer.md
Name: sigma_stim_sequencer

Overview:
- Synthesizable programmable stimulus sequencer that drives one flexdpe input port (data, valid, stationary, destination, VN separator).
- Holds a DEPTH-entry command table loaded over a write port, then replays entries 0..N-1 for a programmable number of passes.
- On passes after the first, stationary entries are suppressed so the loaded stationary operands are reused while streaming entries repeat.
- Honours a ready back-pressure input and sits between a host/DMA loader and flexdpe.

Parameters:
IN_DATA_TYPE, 16, input element width
NUM_PES, 32, number of PE lanes
LOG2_PES, 5, log2(NUM_PES)
DEPTH, 16, command table entries
LOG2_DEPTH, 4, log2(DEPTH)
REP_W, 8, width of repeat count

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
i_wr_en  in  1  table write strobe
i_wr_addr  in  LOG2_DEPTH  table write address
i_wr_data  in  NUM_PES*IN_DATA_TYPE  entry data bus
i_wr_dest  in  NUM_PES*LOG2_PES  entry destination bus
i_wr_vn  in  NUM_PES*LOG2_PES  entry VN separator
i_wr_stationary  in  1  entry stationary flag
i_wr_valid  in  1  entry data-valid flag
i_start  in  1  start pulse
i_num_entries  in  LOG2_DEPTH+1  entries per pass
i_repeat  in  REP_W  pass count
i_abort  in  1  abort sequence
i_ready  in  1  downstream can accept this cycle
o_data_valid  out  1  to flexdpe i_data_valid
o_data_bus  out  NUM_PES*IN_DATA_TYPE  to flexdpe i_data_bus
o_stationary  out  1  to flexdpe i_stationary
o_dest_bus  out  NUM_PES*LOG2_PES  to flexdpe i_dest_bus
o_vn_seperator  out  NUM_PES*LOG2_PES  to flexdpe i_vn_seperator
o_busy  out  1  state is RUN
o_done  out  1  one-cycle completion pulse
o_issue_count  out  16  entries issued since last start

Behaviour:
- Reset (rst=0 at a posedge): state IDLE; ptr=0; pass=0; all outputs 0, including o_issue_count. Table contents are not reset.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE: drive all data outputs to 0.
- IDLE/DONE: writes are accepted; i_wr_en writes all five fields at i_wr_addr on the posedge.
- RUN: writes are ignored and the table is locked.
- IDLE + i_start at edge E0:
  - Latch nent = min(i_num_entries, DEPTH) and nrep = max(i_repeat, 1).
  - Clear o_issue_count, ptr=0, pass=0.
  - If nent=0: go to DONE (o_done=1 after E0); no entry is issued.
  - Otherwise go to RUN; entry 0 appears on outputs after E1, giving a start-to-first-output latency of 2 edges.
- RUN, per posedge:
  - i_ready=0: outputs forced to 0; ptr/pass hold.
  - i_ready=1, entry[ptr] stationary and pass>0: suppressed; outputs 0 for that cycle, ptr advances, count unchanged.
  - i_ready=1 otherwise: issue. Outputs take entry[ptr] (o_data_valid = stored valid flag), ptr advances, o_issue_count +1 (saturates at 16'hFFFF).
  - Pointer wrap: when ptr=nent-1 advances, ptr=0 and pass+1. If pass+1=nrep, go to DONE.
- DONE: o_done=1 for exactly one cycle; data outputs 0 during that cycle; next edge goes to IDLE. o_busy=0.
- o_issue_count holds its value until the next accepted start.
- i_start while in RUN or DONE is ignored.
- i_abort in RUN or DONE: next edge goes to IDLE; outputs 0; o_done not asserted. i_abort has priority over issue and over i_start.
- i_wr_en together with i_start in IDLE: the write completes first; start latches parameters on the same edge, so entry E is available at E1.
- rst low mid-RUN: immediately returns to the reset state at that edge.

Test Plan:
- Load 6 entries: e0 stationary with data 0x3F80 in all lanes; e1..e5 streaming. Start with nent=6, rep=1, ready=1 -> outputs e0..e5 on 6 consecutive cycles starting 2 edges after start; o_stationary=1 only for e0; o_done pulse on the next cycle; o_issue_count=6.
- Same table with rep=3 -> pass0 issues e0..e5; passes 1 and 2 show a zero/invalid cycle at e0's slot followed by e1..e5; o_issue_count=16; one o_done.
- rep=1 with i_ready toggling 1,0,1,0 -> each entry is held back during the ready=0 cycles, those cycles output 0, order is preserved, and no entry is lost or duplicated; count=6.
- Start with nent=0 -> o_done the cycle after start, o_data_valid never 1, o_issue_count=0. Start with nent=20 (DEPTH=16) -> 16 entries issued.
- Abort asserted on the 3rd issue cycle -> next cycle outputs are 0, o_busy=0, no o_done, o_issue_count=3. A write during RUN, read back through a later run, shows the old value.
- Reset asserted mid-RUN for 1 cycle -> all outputs 0 and IDLE. A new start then replays the intact table from entry 0.
